// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side bus of mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              grant_d;
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, grant_d, busy
    );
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, grant_d, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports, data wins by default.
// Defining MEM_ARB_FAIRNESS_EN adds a streak counter that bounds fetch starvation to STREAK_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STREAK_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t            state, state_nx;
    logic              pick_d, i_over, start;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
    logic              we_q, grant_q;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [3:0] streak;
    assign i_over = bus.i_req && streak == 4'(STREAK_MAX);
    always_ff @(posedge clk or negedge rst)
        if (!rst) streak <= '0;
        else if (state == IDLE) streak <= (bus.i_req && pick_d) ? streak + 4'd1 : '0;
`else
    logic [3:0] unused_streak_max;
    assign unused_streak_max = 4'(STREAK_MAX);
    assign i_over = 1'b0;
`endif

    assign pick_d = bus.d_req && !i_over;
    assign start  = state == IDLE && (bus.i_req || bus.d_req);

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx      = state == IDLE ? (start ? BUSY : IDLE) :
                        state == BUSY ? (bus.mem_ready ? RESP : BUSY) : IDLE;
        bus.mem_en    = state == BUSY;
        bus.mem_we    = state == BUSY && we_q;
        bus.i_ack     = state == RESP && !grant_q;
        bus.d_ack     = state == RESP && grant_q;
        bus.busy      = state != IDLE;
        bus.grant_d   = grant_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.i_rdata   = i_rdata_q;
        bus.d_rdata   = d_rdata_q;
    end

    // Command registers are loaded once at arbitration and held through wait states.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            grant_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (start) begin
                grant_q <= pick_d;
                addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
                wdata_q <= pick_d ? bus.d_wdata : '0;
                we_q    <= pick_d && bus.d_we;
            end
            if (state == BUSY && bus.mem_ready && !grant_q) i_rdata_q <= bus.mem_rdata;
            if (state == BUSY && bus.mem_ready && grant_q && !we_q) d_rdata_q <= bus.mem_rdata;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plan steps then randomized traffic against a request-level model.
// Follows MEM_ARB_FAIRNESS_EN so the expected grant order matches the build.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int STREAK_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(STREAK_MAX)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, errors so far %0d", n_err);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] mem [16];
    logic        pr_i = 0, pr_d = 0, prev_en = 0, nx_ai = 0, nx_ad = 0;
    logic        own_d = 0, own_we = 0, want_d = 0;
    logic [31:0] rd_val = 0, m_ird = 0, m_drd = 0;
    int          streak = 0, g = 0, iack_cnt = 0;

    initial begin
        bus.i_req = 1; bus.i_addr = 0; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8;
        bus.d_wdata = 0; bus.mem_ready = 1; bus.mem_rdata = 0;
        step(); step();
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_acks", {bus.i_ack, bus.d_ack}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant_d, 0);
        chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        rst = 1;
        step();
        chk("first_grant_d", bus.grant_d, 1);
        chk("first_addr", bus.mem_addr, 8);
        bus.mem_rdata = 32'h55;
        step();
        chk("first_d_ack", {bus.i_ack, bus.d_ack}, 2'b01);
        chk("first_d_rdata", bus.d_rdata, 32'h55);
        bus.d_req = 0;
        step();
        chk("resp_to_idle", {bus.busy, bus.mem_en, bus.d_ack}, 0);
        step();
        chk("fetch_en", bus.mem_en, 1);
        chk("fetch_addr", bus.mem_addr, 0);
        chk("fetch_grant", bus.grant_d, 0);
        bus.mem_rdata = 32'h20020005;
        step();
        chk("fetch_ack", {bus.i_ack, bus.d_ack}, 2'b10);
        chk("fetch_rdata", bus.i_rdata, 32'h20020005);
        bus.i_req = 0;
        step();
        chk("fetch_pulse", bus.i_ack, 0);
        chk("d_rdata_hold", bus.d_rdata, 32'h55);

        bus.i_req = 1; bus.i_addr = 4; bus.d_req = 1; bus.d_we = 1; bus.d_addr = 84; bus.d_wdata = 7;
        step();
        chk("cf_cmd", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 32'd84, 32'd7});
        step();
        chk("cf_d_ack", {bus.i_ack, bus.d_ack, bus.mem_en, bus.mem_we}, 4'b0100);
        chk("cf_wr_keeps_rdata", bus.d_rdata, 32'h55);
        bus.d_req = 0;
        step();
        chk("cf_idle", bus.mem_en, 0);
        bus.mem_rdata = 32'h99;
        step();
        chk("cf_fetch", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 32'd4});
        step();
        chk("cf_i_ack", {bus.i_ack, bus.i_rdata}, {1'b1, 32'h99});
        bus.i_req = 0;
        step();

        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 80; bus.mem_rdata = 7;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("ws_cmd", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.d_ack}, {1'b1, 1'b0, 32'd80, 1'b0});
            bus.mem_ready = k == 3;
            step();
        end
        chk("ws_ack", {bus.d_ack, bus.d_rdata, bus.mem_we}, {1'b1, 32'd7, 1'b0});
        bus.d_req = 0;
        step();

        bus.i_req = 1; bus.i_addr = 32'h40; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h44;
        prev_en = 0;
        for (int c = 0; c < 40 && g < 10; c++) begin
            step();
            if (bus.i_ack) iack_cnt++;
            if (bus.mem_en && !prev_en) begin
                chk("fair_grant", bus.grant_d, FAIR ? (g % (STREAK_MAX + 1) != STREAK_MAX) : 1'b1);
                g++;
            end
            prev_en = bus.mem_en;
        end
        chk("fair_grants", g, 10);
        chk("fair_i_acks", iack_cnt, FAIR ? 1 : 0);
        bus.i_req = 0; bus.d_req = 0;
        repeat (4) step();

        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h10; bus.mem_ready = 0;
        step();
        chk("rb_busy", {bus.mem_en, bus.mem_we}, 2'b11);
        #2 rst = 0;
        #1;
        chk("rb_async", {bus.mem_en, bus.mem_we, bus.busy, bus.mem_addr}, 0);
        bus.d_req = 0;
        step();
        rst = 1;
        step();
        chk("rb_no_ack", {bus.d_ack, bus.i_ack, bus.busy}, 0);
        step();
        chk("rb_idle", bus.mem_en, 0);

        foreach (mem[k]) mem[k] = $urandom;
        prev_en = 0;
        for (int c = 0; c < 1500; c++) begin
            step();
            if (nx_ai) m_ird = rd_val;
            if (nx_ad && !own_we) m_drd = rd_val;
            chk("r_i_ack", bus.i_ack, nx_ai);
            chk("r_d_ack", bus.d_ack, nx_ad);
            chk("r_i_rdata", bus.i_rdata, m_ird);
            chk("r_d_rdata", bus.d_rdata, m_drd);
            chk("r_we_idle", bus.mem_we & ~bus.mem_en, 1'b0);
            // A new command appears exactly one cycle after the IDLE cycle that saw pr_i/pr_d.
            if (bus.mem_en && !prev_en) begin
                want_d = pr_d && !(FAIR && pr_i && streak == STREAK_MAX);
                streak = (want_d && pr_i) ? streak + 1 : 0;
                chk("r_grant", bus.grant_d, want_d);
                chk("r_addr", bus.mem_addr, want_d ? bus.d_addr : bus.i_addr);
                chk("r_we", bus.mem_we, want_d && bus.d_we);
                if (want_d && bus.d_we) chk("r_wdata", bus.mem_wdata, bus.d_wdata);
                own_d = want_d;
                own_we = want_d && bus.d_we;
            end
            if (nx_ai) bus.i_req = 0;
            else if (!bus.i_req && $urandom_range(0, 2) == 0) begin
                bus.i_req = 1;
                bus.i_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (nx_ad) bus.d_req = 0;
            else if (!bus.d_req && $urandom_range(0, 2) == 0) begin
                bus.d_req = 1;
                bus.d_we = 1'($urandom_range(0, 1));
                bus.d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                bus.d_wdata = $urandom;
            end
            nx_ai = 0;
            nx_ad = 0;
            if (bus.mem_en) begin
                bus.mem_ready = $urandom_range(0, 2) != 0;
                rd_val = mem[bus.mem_addr[5:2]];
                bus.mem_rdata = bus.mem_ready ? rd_val : $urandom;
                if (bus.mem_ready && bus.mem_we) mem[bus.mem_addr[5:2]] = bus.mem_wdata;
                nx_ai = bus.mem_ready && !own_d;
                nx_ad = bus.mem_ready && own_d;
            end else bus.mem_ready = 1'($urandom_range(0, 1));
            pr_i = bus.i_req;
            pr_d = bus.d_req;
            prev_en = bus.mem_en;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
